// File: rtl/led_pwm_sb_ctrl.sv
// Bus-mapped multi-channel LED controller: per-channel PWM brightness,
// a global blink mode with programmable half-period, and a registered read path.
module led_pwm_sb_ctrl #(
  parameter int unsigned NUM_LEDS       = 16,
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned DEFAULT_PERIOD = 10_000_000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                write_enable_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         write_data_i,
  output logic [31:0]         read_data_o,
  output logic [NUM_LEDS-1:0] led_o
);

  localparam logic [23:0] ADDR_VALUE  = 24'h00;
  localparam logic [23:0] ADDR_MODE   = 24'h04;
  localparam logic [23:0] ADDR_PERIOD = 24'h08;
  localparam logic [23:0] ADDR_STATUS = 24'h0C;
  localparam logic [23:0] ADDR_RESET  = 24'h24;
  localparam logic [23:0] ADDR_DUTY   = 24'h40;

  localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
  localparam logic [31:0]         PERIOD_RV = 32'(DEFAULT_PERIOD);

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_BLINK  = 1'b1;

  logic [23:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic        soft_rst;
  logic        unused_addr;

  logic [NUM_LEDS-1:0] value_q, value_d;
  logic                mode_q, mode_d;
  logic [31:0]         period_q, period_d;
  logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_d [NUM_LEDS];
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0]         blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_LEDS-1:0] pwm_on;

  assign addr        = addr_i[23:0];
  assign unused_addr = ^addr_i[31:24];
  assign wr_en       = req_i & write_enable_i;
  assign rd_en       = req_i & ~write_enable_i;
  assign soft_rst    = wr_en && (addr == ADDR_RESET);

  // All-ones duty is forced on so full brightness has no one-clock gap.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      pwm_on[i] = (duty_q[i] == PWM_MAX) || (pwm_cnt_q < duty_q[i]);
    end
  end

  always_comb begin
    value_d     = value_q;
    mode_d      = mode_q;
    period_d    = period_q;
    duty_d      = duty_q;
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    blink_cnt_d = 32'd0;
    phase_d     = 1'b1;
    led_d       = value_q & pwm_on & {NUM_LEDS{phase_q}};
    rdata_d     = rdata_q;

    // Blink counter only runs in BLINK; STATIC parks it at zero, phase on.
    if (mode_q == MODE_BLINK) begin
      if (blink_cnt_q == period_q - 32'd1) begin
        blink_cnt_d = 32'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        phase_d     = phase_q;
      end
    end

    if (wr_en) begin
      case (addr)
        ADDR_VALUE: value_d = write_data_i[NUM_LEDS-1:0];
        ADDR_MODE:  mode_d  = write_data_i[0];
        ADDR_PERIOD: begin
          period_d    = (write_data_i == 32'd0) ? 32'd1 : write_data_i;
          blink_cnt_d = 32'd0;
          phase_d     = phase_q;
        end
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (addr == ADDR_DUTY + 24'(4 * i)) begin
              duty_d[i] = write_data_i[PWM_BITS-1:0];
            end
          end
        end
      endcase
    end

    if (rd_en) begin
      rdata_d = 32'd0;
      case (addr)
        ADDR_VALUE:  rdata_d = 32'(value_q);
        ADDR_MODE:   rdata_d = 32'(mode_q);
        ADDR_PERIOD: rdata_d = period_q;
        ADDR_STATUS: rdata_d = 32'(phase_q);
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (addr == ADDR_DUTY + 24'(4 * i)) begin
              rdata_d = 32'(duty_q[i]);
            end
          end
        end
      endcase
    end

    // Soft reset wins over the write it arrives with; read data is left alone.
    if (soft_rst) begin
      value_d     = '0;
      mode_d      = MODE_STATIC;
      period_d    = PERIOD_RV;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty_d[i] = PWM_MAX;
      end
      pwm_cnt_d   = '0;
      blink_cnt_d = 32'd0;
      phase_d     = 1'b1;
      led_d       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q     <= '0;
      mode_q      <= MODE_STATIC;
      period_q    <= PERIOD_RV;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty_q[i] <= PWM_MAX;
      end
      pwm_cnt_q   <= '0;
      blink_cnt_q <= 32'd0;
      phase_q     <= 1'b1;
      led_q       <= '0;
      rdata_q     <= 32'd0;
    end else begin
      value_q     <= value_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      rdata_q     <= rdata_d;
    end
  end

  assign read_data_o = rdata_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_led_pwm_sb_ctrl.sv
// Scoreboard bench for led_pwm_sb_ctrl: expectations are queued as stimulus
// is issued and popped when the registered read data or LED output is sampled.
module tb_led_pwm_sb_ctrl;

  localparam int unsigned NL = 16;
  localparam int unsigned PB = 8;
  localparam int unsigned DP = 1000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          we_i;
  logic [31:0]   addr_i;
  logic [31:0]   wdata_i;
  logic [31:0]   rdata_o;
  logic [NL-1:0] led_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  led_pwm_sb_ctrl #(.NUM_LEDS(NL), .PWM_BITS(PB), .DEFAULT_PERIOD(DP)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .write_enable_i (we_i),
    .addr_i         (addr_i),
    .write_data_i   (wdata_i),
    .read_data_o    (rdata_o),
    .led_o          (led_o)
  );

  // Bus tasks start and end on a falling edge so accesses chain back to back.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(negedge clk);
    req_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5] = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h0C};
    logic [31:0] exps  [5] = '{32'h0, 32'h0, 32'(DP), 32'hFF, 32'h1};
    logic [31:0] got, e;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if (32'(led_o) !== e) begin
      miscompares++; $display("FAIL reset_led got=%h exp=%h", led_o, e);
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if (rdata_o !== e) begin
      miscompares++; $display("FAIL reset_rdata got=%h exp=%h", rdata_o, e);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(exps[i]);
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i], got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], got, e);
      end
    end
  endtask

  task automatic test_static();
    logic [31:0] got, e;
    bus_write(32'h00, 32'hFFFF_A5A5);
    @(negedge clk);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h0000_A5A5);
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (32'(led_o) !== e) begin
        miscompares++; $display("FAIL static_led cycle=%0d got=%h exp=%h", k, led_o, e);
      end
      @(negedge clk);
    end
    exp_q.push_back(32'h0000_A5A5);
    bus_read(32'h00, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++; $display("FAIL value_readback got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_pwm();
    logic [31:0] got, e;
    int on_cnt, other_cnt;
    bus_write(32'h44, 32'hFFFF_FF12);
    bus_write(32'h54, 32'h37);
    exp_q.push_back(32'h12);
    exp_q.push_back(32'h37);
    bus_read(32'h44, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++; $display("FAIL duty1_readback got=%h exp=%h", got, e);
    end
    bus_read(32'h54, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++; $display("FAIL duty5_readback got=%h exp=%h", got, e);
    end
    bus_write(32'h44, 32'hFF);
    bus_write(32'h54, 32'hFF);
    for (int pass = 0; pass < 2; pass++) begin
      bus_write(32'h40, (pass == 0) ? 32'd64 : 32'd0);
      bus_write(32'h00, 32'h1);
      exp_q.push_back((pass == 0) ? 32'd64 : 32'd0);
      exp_q.push_back(32'd0);
      repeat (2) @(negedge clk);
      on_cnt = 0; other_cnt = 0;
      for (int k = 0; k < 256; k++) begin
        if (led_o[0]) on_cnt++;
        if (led_o[NL-1:1] != '0) other_cnt++;
        @(negedge clk);
      end
      e = exp_q.pop_front(); vectors++;
      if (32'(on_cnt) !== e) begin
        miscompares++; $display("FAIL pwm_on_count pass=%0d got=%0d exp=%0d", pass, on_cnt, e);
      end
      e = exp_q.pop_front(); vectors++;
      if (32'(other_cnt) !== e) begin
        miscompares++; $display("FAIL pwm_other_chans pass=%0d got=%0d exp=%0d", pass, other_cnt, e);
      end
    end
    bus_write(32'h40, 32'hFF);
  endtask

  task automatic test_blink();
    logic [31:0] got, e;
    logic        ph;
    bus_write(32'h00, 32'hFFFF);
    bus_write(32'h08, 32'd4);
    bus_write(32'h04, 32'd1);
    // LED lags the phase register by one clock; sample 0 still reflects STATIC.
    for (int k = 0; k < 24; k++) begin
      ph = (k == 0) ? 1'b1 : ((((k - 1) / 4) % 2) == 0);
      exp_q.push_back(ph ? 32'hFFFF : 32'h0);
    end
    for (int k = 0; k < 24; k++) begin
      e = exp_q.pop_front(); vectors++;
      if (32'(led_o) !== e) begin
        miscompares++; $display("FAIL blink_led cycle=%0d got=%h exp=%h", k, led_o, e);
      end
      @(negedge clk);
    end
    for (int j = 24; j < 30; j++) exp_q.push_back(32'(((j / 4) % 2) == 0));
    for (int j = 24; j < 30; j++) begin
      bus_read(32'h0C, got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL blink_status step=%0d got=%h exp=%h", j, got, e);
      end
    end
    bus_write(32'h08, 32'd0);
    exp_q.push_back(32'd1);
    bus_read(32'h08, got);
    e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++; $display("FAIL period_zero got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] addrs [6] = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h0C, 32'h5C};
    logic [31:0] exps  [6] = '{32'h0, 32'h0, 32'(DP), 32'hFF, 32'h1, 32'hFF};
    logic [31:0] got, e;
    bus_write(32'h5C, 32'h03);
    bus_write(32'h24, 32'hFFFF_FFFF);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); vectors++;
    if (rdata_o !== e) begin
      miscompares++; $display("FAIL soft_rst_rdata_kept got=%h exp=%h", rdata_o, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (32'(led_o) !== e) begin
      miscompares++; $display("FAIL soft_rst_led got=%h exp=%h", led_o, e);
    end
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (32'(led_o) !== e) begin
      miscompares++; $display("FAIL soft_rst_led_next got=%h exp=%h", led_o, e);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(exps[i]);
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL soft_rst_read addr=%h got=%h exp=%h", addrs[i], got, e);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [9] = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h7C,
                               32'h100, 32'h80, 32'h24, 32'h0100_0000};
    logic [31:0] exps  [9] = '{32'h1234, 32'h0, 32'(DP), 32'hFF, 32'hFF,
                               32'h0, 32'h0, 32'h0, 32'h1234};
    logic [31:0] got, e;
    bus_write(32'h00, 32'h1234);
    bus_write(32'h100, 32'hFFFF_FFFF);
    bus_write(32'h80, 32'h0);
    bus_write(32'h0C, 32'h0);
    bus_write(32'h42, 32'h0);
    for (int i = 0; i < 9; i++) exp_q.push_back(exps[i]);
    for (int i = 0; i < 9; i++) begin
      bus_read(addrs[i], got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL unmapped_read addr=%h got=%h exp=%h", addrs[i], got, e);
      end
    end
  endtask

  task automatic test_hard_reset_mid();
    logic [31:0] addrs [4] = '{32'h00, 32'h04, 32'h08, 32'h0C};
    logic [31:0] exps  [4] = '{32'h0, 32'h0, 32'(DP), 32'h1};
    logic [31:0] got, e;
    bus_write(32'h00, 32'hFFFF);
    bus_write(32'h08, 32'd3);
    bus_write(32'h04, 32'd1);
    repeat (5) @(negedge clk);
    bus_read(32'h08, got);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); vectors++;
    if (32'(led_o) !== e) begin
      miscompares++; $display("FAIL hard_rst_led got=%h exp=%h", led_o, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (rdata_o !== e) begin
      miscompares++; $display("FAIL hard_rst_rdata got=%h exp=%h", rdata_o, e);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(exps[i]);
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], got);
      e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++; $display("FAIL hard_rst_read addr=%h got=%h exp=%h", addrs[i], got, e);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    @(negedge clk);
    test_reset();
    test_static();
    test_pwm();
    test_blink();
    test_soft_reset();
    test_unmapped();
    test_hard_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
